// File: rtl/signal_tagger_pkg.sv
// Shared definitions for signal_event_tagger: event type codes, FSM state
// encoding and the layout of the event word {type, delta, ts}.
package signal_tagger_pkg;

    localparam logic [1:0] TYPE_CH1   = 2'b01;
    localparam logic [1:0] TYPE_CH2   = 2'b10;
    localparam logic [1:0] TYPE_COINC = 2'b11;

    localparam int TYPE_W  = 2;
    localparam int DELTA_W = 6;
    localparam int HDR_W   = TYPE_W + DELTA_W;
    localparam int TS_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } tagger_state_t;

    // Field offsets depend on the timestamp width chosen by the instantiating module.
    function automatic int delta_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int type_lsb(input int ts_w);
        return ts_w + DELTA_W;
    endfunction

endpackage

// File: rtl/tagger_fifo.sv
// First-word fall-through FIFO for event words: the head word is visible on
// rd_data whenever empty is low. A push while full is dropped unless a pop happens in the same cycle.
module tagger_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/signal_event_tagger.sv
// Timestamps rising edges on two signal lines, pairs them into coincidences
// within COINC_WINDOW cycles, and queues event words in a FWFT FIFO.
// Optional per-channel deadtime is enabled by defining SIGNAL_TAGGER_DEADTIME_EN.
module signal_event_tagger
    import signal_tagger_pkg::*;
#(
    parameter int TS_WIDTH     = 24,
    parameter int COINC_WINDOW = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DEADTIME     = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            SIGNAL_LINE_1,
    input  logic                            SIGNAL_LINE_2,
    input  logic                            enable,
    input  logic                            rd_en,
    output logic                            evt_valid,
    output logic [TS_WIDTH+7:0]             evt_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [15:0]                     overflow_count
);
    localparam int                 EVT_W     = TS_WIDTH + HDR_W;
    localparam int                 DT_W      = $clog2(DEADTIME + 2);
    localparam int                 DELTA_LSB = delta_lsb(TS_WIDTH);
    localparam int                 TYPE_LSB  = type_lsb(TS_WIDTH);
    localparam logic [DELTA_W-1:0] WINDOW    = DELTA_W'(COINC_WINDOW);

    tagger_state_t       state;
    tagger_state_t       state_n;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_lat;
    logic [TS_WIDTH-1:0] ts_lat_n;
    logic [DELTA_W-1:0]  win_cnt;
    logic [DELTA_W-1:0]  win_cnt_n;
    logic [DELTA_W-1:0]  delta;
    logic                prev1;
    logic                prev2;
    logic                edge1;
    logic                edge2;
    logic [DT_W-1:0]     dt1_cnt;
    logic [DT_W-1:0]     dt2_cnt;
    logic                own_edge;
    logic                other_edge;
    logic [TYPE_W-1:0]   own_type;
    logic                push;
    logic [TYPE_W-1:0]   push_type;
    logic [DELTA_W-1:0]  push_delta;
    logic [TS_WIDTH-1:0] push_ts;
    logic [EVT_W-1:0]    push_word;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_drop;

    assign edge1 = SIGNAL_LINE_1 & ~prev1 & enable & (dt1_cnt == '0);
    assign edge2 = SIGNAL_LINE_2 & ~prev2 & enable & (dt2_cnt == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev1 <= 1'b0;
            prev2 <= 1'b0;
            ts_q  <= '0;
        end else begin
            prev1 <= SIGNAL_LINE_1;
            prev2 <= SIGNAL_LINE_2;
            ts_q  <= enable ? ts_q + TS_WIDTH'(1) : '0;
        end
    end

`ifdef SIGNAL_TAGGER_DEADTIME_EN
    // Counter loads on an accepted edge; the channel is blind until it drains to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dt1_cnt <= '0;
            dt2_cnt <= '0;
        end else begin
            if (edge1) begin
                dt1_cnt <= DT_W'(DEADTIME);
            end else if (dt1_cnt != '0) begin
                dt1_cnt <= dt1_cnt - DT_W'(1);
            end
            if (edge2) begin
                dt2_cnt <= DT_W'(DEADTIME);
            end else if (dt2_cnt != '0) begin
                dt2_cnt <= dt2_cnt - DT_W'(1);
            end
        end
    end
`else
    assign dt1_cnt = '0;
    assign dt2_cnt = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ts_lat  <= '0;
            win_cnt <= '0;
        end else begin
            state   <= state_n;
            ts_lat  <= ts_lat_n;
            win_cnt <= win_cnt_n;
        end
    end

    // WAIT1 and WAIT2 share one branch: "own" is the channel that opened the window.
    always_comb begin
        state_n    = state;
        ts_lat_n   = ts_lat;
        win_cnt_n  = win_cnt;
        delta      = win_cnt + DELTA_W'(1);
        push       = 1'b0;
        push_type  = TYPE_COINC;
        push_delta = '0;
        push_ts    = ts_lat;
        own_edge   = edge1;
        other_edge = edge2;
        own_type   = TYPE_CH1;
        if (state == WAIT2) begin
            own_edge   = edge2;
            other_edge = edge1;
            own_type   = TYPE_CH2;
        end

        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (edge1 && edge2) begin
                        push      = 1'b1;
                        push_type = TYPE_COINC;
                        push_ts   = ts_q;
                    end else if (edge1 || edge2) begin
                        ts_lat_n  = ts_q;
                        win_cnt_n = '0;
                        state_n   = edge1 ? WAIT1 : WAIT2;
                    end
                end
                WAIT1, WAIT2: begin
                    if (other_edge) begin
                        push       = 1'b1;
                        push_type  = TYPE_COINC;
                        push_delta = delta;
                        if (own_edge) begin
                            ts_lat_n  = ts_q;
                            win_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (own_edge) begin
                        push      = 1'b1;
                        push_type = own_type;
                        ts_lat_n  = ts_q;
                        win_cnt_n = '0;
                    end else if (delta == WINDOW) begin
                        push      = 1'b1;
                        push_type = own_type;
                        state_n   = IDLE;
                    end else begin
                        win_cnt_n = delta;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        push_word                            = '0;
        push_word[TS_LSB +: TS_WIDTH]        = push_ts;
        push_word[DELTA_LSB +: DELTA_W]      = push_delta;
        push_word[TYPE_LSB +: TYPE_W]        = push_type;
    end

    tagger_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .wr_data (push_word),
        .pop     (rd_en),
        .rd_data (evt_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .drop    (fifo_drop),
        .count   (fifo_count)
    );

    assign evt_valid = ~fifo_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overflow_count <= '0;
        end else if (fifo_drop && fifo_full && overflow_count != 16'hFFFF) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_signal_event_tagger.sv
// Directed self-checking bench for signal_event_tagger (COINC_WINDOW=8, FIFO_DEPTH=16).
module tb_signal_event_tagger;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        SIGNAL_LINE_1 = 1'b0;
    logic        SIGNAL_LINE_2 = 1'b0;
    logic        enable = 1'b0;
    logic        rd_en = 1'b0;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic [4:0]  fifo_count;
    logic [15:0] overflow_count;

    int checks = 0;
    int failures = 0;
    int tb_ts = 0;

    signal_event_tagger #(
        .TS_WIDTH     (24),
        .COINC_WINDOW (8),
        .FIFO_DEPTH   (16),
        .DEADTIME     (16)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .SIGNAL_LINE_1  (SIGNAL_LINE_1),
        .SIGNAL_LINE_2  (SIGNAL_LINE_2),
        .enable         (enable),
        .rd_en          (rd_en),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .fifo_count     (fifo_count),
        .overflow_count (overflow_count)
    );

    always #5 CLK = ~CLK;

    // Reference timestamp: the value the DUT latches for an edge sampled at the next posedge.
    always @(posedge CLK or posedge RST) begin
        if (RST) tb_ts <= 0;
        else     tb_ts <= enable ? tb_ts + 1 : 0;
    end

    function automatic logic [31:0] ew(input logic [1:0] ty, input int d, input int ts);
        return {ty, 6'(d), 24'(ts)};
    endfunction

    task automatic wait_ts(input int t);
        int n = 0;
        while (tb_ts != t && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (tb_ts != t) begin
            checks++;
            failures++;
            $display("FAIL wait_ts: timestamp %0d never reached, stuck at %0d", t, tb_ts);
        end
    endtask

    task automatic pulse(input logic [1:0] mask, input int t);
        wait_ts(t);
        SIGNAL_LINE_1 = mask[0];
        SIGNAL_LINE_2 = mask[1];
        @(negedge CLK);
        SIGNAL_LINE_1 = 1'b0;
        SIGNAL_LINE_2 = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        checks++; if (evt_valid !== 1'b0)      begin failures++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++; if (evt_data !== 32'h0)      begin failures++; $display("FAIL reset_data: got %h expected 0", evt_data); end
        checks++; if (fifo_count !== 5'd0)     begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow_count !== 16'd0) begin failures++; $display("FAIL reset_overflow: got %0d expected 0", overflow_count); end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_ch1_only();
        pulse(2'b01, 100);
        wait_ts(108);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ch1_early: valid %b expected 0 before window end", evt_valid); end
        wait_ts(109);
        checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b01, 0, 100) || fifo_count !== 5'd1) begin
            failures++; $display("FAIL ch1_only: valid %b data %h count %0d expected 1 %h 1", evt_valid, evt_data, fifo_count, ew(2'b01, 0, 100));
        end
        pop();
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ch1_pop: valid %b expected 0", evt_valid); end
    endtask

    task automatic test_coinc_delta();
        pulse(2'b01, 200);
        pulse(2'b10, 203);
        checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b11, 3, 200)) begin
            failures++; $display("FAIL coinc_delta: valid %b data %h expected 1 %h", evt_valid, evt_data, ew(2'b11, 3, 200));
        end
        wait_ts(215);
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL coinc_single: count %0d expected 1", fifo_count); end
        pop();
    endtask

    task automatic test_coinc_same();
        pulse(2'b11, 300);
        checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b11, 0, 300)) begin
            failures++; $display("FAIL coinc_same: valid %b data %h expected 1 %h", evt_valid, evt_data, ew(2'b11, 0, 300));
        end
        wait_ts(312);
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL coinc_same_count: count %0d expected 1", fifo_count); end
        pop();
    endtask

    task automatic test_outside_window();
        pulse(2'b10, 400);
        pulse(2'b01, 409);
        wait_ts(420);
        checks++; if (fifo_count !== 5'd2 || evt_data !== ew(2'b10, 0, 400)) begin
            failures++; $display("FAIL outside_first: count %0d data %h expected 2 %h", fifo_count, evt_data, ew(2'b10, 0, 400));
        end
        pop();
        checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b01, 0, 409)) begin
            failures++; $display("FAIL outside_second: valid %b data %h expected 1 %h", evt_valid, evt_data, ew(2'b01, 0, 409));
        end
        pop();
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL outside_empty: valid %b expected 0", evt_valid); end
    endtask

    task automatic test_overflow();
        int exp_ts;
        for (int i = 0; i < 19; i++) pulse(2'b01, 500 + 20 * i);
        wait_ts(875);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_count: count %0d expected 16", fifo_count); end
        checks++; if (overflow_count !== 16'd3) begin failures++; $display("FAIL overflow: got %0d expected 3", overflow_count); end
        checks++; if (evt_data !== ew(2'b01, 0, 500)) begin failures++; $display("FAIL full_head: got %h expected %h", evt_data, ew(2'b01, 0, 500)); end
        // Push and pop in the same cycle while full.
        pulse(2'b01, 900);
        wait_ts(908);
        pop();
        checks++; if (fifo_count !== 5'd16 || overflow_count !== 16'd3 || evt_data !== ew(2'b01, 0, 520)) begin
            failures++; $display("FAIL full_push_pop: count %0d ovf %0d head %h expected 16 3 %h", fifo_count, overflow_count, evt_data, ew(2'b01, 0, 520));
        end
        for (int i = 0; i < 16; i++) begin
            exp_ts = (i < 15) ? 520 + 20 * i : 900;
            checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b01, 0, exp_ts)) begin
                failures++; $display("FAIL drain_%0d: valid %b data %h expected 1 %h", i, evt_valid, evt_data, ew(2'b01, 0, exp_ts));
            end
            pop();
        end
        checks++; if (evt_valid !== 1'b0 || fifo_count !== 5'd0) begin
            failures++; $display("FAIL drained: valid %b count %0d expected 0 0", evt_valid, fifo_count);
        end
        pop();
        checks++; if (fifo_count !== 5'd0 || evt_valid !== 1'b0) begin
            failures++; $display("FAIL pop_empty: count %0d valid %b expected 0 0", fifo_count, evt_valid);
        end
    endtask

    task automatic test_disable();
        pulse(2'b01, 1000);
        @(negedge CLK);
        @(negedge CLK);
        enable = 1'b0;
        repeat (15) @(negedge CLK);
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL disable_discard: count %0d expected 0", fifo_count); end
        enable = 1'b1;
        pulse(2'b01, 5);
        wait_ts(14);
        checks++; if (evt_valid !== 1'b1 || evt_data !== ew(2'b01, 0, 5)) begin
            failures++; $display("FAIL ts_restart: valid %b data %h expected 1 %h", evt_valid, evt_data, ew(2'b01, 0, 5));
        end
    endtask

    task automatic test_async_reset();
        pulse(2'b01, 30);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_data !== 32'h0 || fifo_count !== 5'd0 || overflow_count !== 16'd0) begin
            failures++; $display("FAIL async_reset: valid %b data %h count %0d ovf %0d expected all 0", evt_valid, evt_data, fifo_count, overflow_count);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        checks++; if (fifo_count !== 5'd0 || evt_valid !== 1'b0) begin
            failures++; $display("FAIL reset_no_event: count %0d valid %b expected 0 0", fifo_count, evt_valid);
        end
    endtask

    task automatic test_deadtime();
        pulse(2'b01, 50);
        pulse(2'b01, 55);
        wait_ts(70);
`ifdef SIGNAL_TAGGER_DEADTIME_EN
        checks++; if (fifo_count !== 5'd1 || evt_data !== ew(2'b01, 0, 50)) begin
            failures++; $display("FAIL deadtime: count %0d head %h expected 1 %h", fifo_count, evt_data, ew(2'b01, 0, 50));
        end
        pop();
`else
        checks++; if (fifo_count !== 5'd2 || evt_data !== ew(2'b01, 0, 50)) begin
            failures++; $display("FAIL repeat_first: count %0d head %h expected 2 %h", fifo_count, evt_data, ew(2'b01, 0, 50));
        end
        pop();
        checks++; if (evt_data !== ew(2'b01, 0, 55)) begin
            failures++; $display("FAIL repeat_second: got %h expected %h", evt_data, ew(2'b01, 0, 55));
        end
        pop();
`endif
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL repeat_empty: valid %b expected 0", evt_valid); end
    endtask

    initial begin
        #1;
        test_reset();
        test_ch1_only();
        test_coinc_delta();
        test_coinc_same();
        test_outside_window();
        test_overflow();
        test_disable();
        test_async_reset();
        test_deadtime();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
